fp_normalize: RTL and testbench

FP_NORMALIZE -- requirements
Module: fp_normalize

---
 rtl/fp_pkg.sv | 21 ++
 rtl/fp_pack.sv | 35 +++
 rtl/fp_normalize.sv | 122 ++++++++++++
 tb/tb_fp_normalize.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point normalisation stage.
package fp_pkg;

    localparam int EXP_W_DEF  = 8;
    localparam int MANT_W_DEF = 23;

    localparam logic [7:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp_pack.sv
// Combinational packer: turns sign/exponent/fraction plus the special-case
// conditions into the packed result word and the {overflow, underflow, zero} flags.
module fp_pack
    import fp_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic                    sign,
    input  logic [EXP_W-1:0]        exp,
    input  logic [MANT_W-1:0]       frac,
    input  logic                    ovf,
    input  logic                    unf,
    input  logic                    zero,
    output logic [EXP_W+MANT_W:0]   result,
    output logic [2:0]              flags
);

    // Zero and underflow both flush to a positive zero; overflow saturates to infinity.
    always_comb begin
        result = '0;
        flags  = 3'b000;
        if (zero) begin
            flags = 3'b001;
        end else if (ovf) begin
            result = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            flags  = 3'b100;
        end else if (unf) begin
            flags = 3'b010;
        end else begin
            result = {sign, exp, frac};
        end
    end

endmodule

// File: rtl/fp_normalize.sv
// Post-add normaliser: takes the raw sum, shifts it one bit per cycle until the
// hidden bit is set, and holds the packed result until downstream accepts it.
module fp_normalize
    import fp_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sign_in,
    input  logic [EXP_W-1:0]        exponent_temp,
    input  logic [MANT_W+1:0]       sum_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W:0]   result,
    output logic [2:0]              flags
);

    localparam logic [EXP_W-1:0] EXP_ALL1 = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};

    state_t                  state, state_nxt;
    logic                    sign_r;
    logic [EXP_W-1:0]        exp_r, exp_nxt;
    logic [MANT_W+1:0]       mant_r, mant_nxt;
    logic [EXP_W+MANT_W:0]   result_r, pack_result;
    logic [2:0]              flags_r, pack_flags;
    logic                    ovf, unf, zero;

    // One normalisation decision per SHIFT cycle, highest priority first.
    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_r;
        mant_nxt  = mant_r;
        ovf       = 1'b0;
        unf       = 1'b0;
        zero      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = SHIFT;
                    exp_nxt   = exponent_temp;
                    mant_nxt  = sum_mant;
                end
            end
            SHIFT: begin
                if (mant_r == '0) begin
                    zero      = 1'b1;
                    state_nxt = DONE;
                end else if (exp_r == EXP_ALL1) begin
                    ovf       = 1'b1;
                    state_nxt = DONE;
                end else if (mant_r[MANT_W+1]) begin
                    mant_nxt  = mant_r >> 1;
                    exp_nxt   = exp_r + EXP_ONE;
                    ovf       = (exp_nxt == EXP_ALL1);
                    state_nxt = DONE;
                end else if (mant_r[MANT_W]) begin
                    state_nxt = DONE;
                end else if (exp_r <= EXP_ONE) begin
                    unf       = 1'b1;
                    state_nxt = DONE;
                end else begin
                    mant_nxt  = mant_r << 1;
                    exp_nxt   = exp_r - EXP_ONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    fp_pack #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) u_pack (
        .sign   (sign_r),
        .exp    (exp_nxt),
        .frac   (mant_nxt[MANT_W-1:0]),
        .ovf    (ovf),
        .unf    (unf),
        .zero   (zero),
        .result (pack_result),
        .flags  (pack_flags)
    );

    // Result is captured only on the SHIFT->DONE step so it stays frozen under backpressure.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            sign_r   <= 1'b0;
            exp_r    <= '0;
            mant_r   <= '0;
            result_r <= '0;
            flags_r  <= 3'b000;
        end else begin
            state  <= state_nxt;
            exp_r  <= exp_nxt;
            mant_r <= mant_nxt;
            if (state == IDLE && in_valid) begin
                sign_r <= sign_in;
            end
            if (state == SHIFT && state_nxt == DONE) begin
                result_r <= pack_result;
                flags_r  <= pack_flags;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_r;
    assign flags     = flags_r;

endmodule

// File: tb/tb_fp_normalize.sv
// Directed bench for fp_normalize: hand-computed vectors for normalisation,
// carry, overflow, zero and underflow, plus backpressure and reset scenarios.
module tb_fp_normalize;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [7:0]  exponent_temp;
    logic [24:0] sum_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [2:0]  flags;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [24:0] m;
        int          lat;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    fp_normalize #(.EXP_W(8), .MANT_W(23)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .sign_in       (sign_in),
        .exponent_temp (exponent_temp),
        .sum_mant      (sum_mant),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .flags         (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Presents one operation for a single accept edge, then counts edges until out_valid.
    task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                          output int lat, output bit ready_seen);
        sign_in       = s;
        exponent_temp = e;
        sum_mant      = m;
        in_valid      = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        lat        = -1;
        ready_seen = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = n;
                break;
            end
            if (in_ready) ready_seen = 1'b1;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sign_in   = 1'b0;
        exponent_temp = '0;
        sum_mant  = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
        checks++; if (flags !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", flags); end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_datapath();
        vec_t v[13];
        int   lat;
        bit   rs;
        v[0]  = '{1'b0, 8'd10,  25'h0800000, 1, 32'h05000000, 3'b000};
        v[1]  = '{1'b0, 8'd100, 25'h0C00001, 1, 32'h32400001, 3'b000};
        v[2]  = '{1'b1, 8'd20,  25'h0400000, 2, 32'h89800000, 3'b000};
        v[3]  = '{1'b0, 8'd10,  25'h1000000, 1, 32'h05800000, 3'b000};
        v[4]  = '{1'b0, 8'd10,  25'h1800003, 1, 32'h05C00001, 3'b000};
        v[5]  = '{1'b0, 8'd254, 25'h1000000, 1, 32'h7F800000, 3'b100};
        v[6]  = '{1'b1, 8'd255, 25'h0800000, 1, 32'hFF800000, 3'b100};
        v[7]  = '{1'b0, 8'd50,  25'h0000000, 1, 32'h00000000, 3'b001};
        v[8]  = '{1'b1, 8'd50,  25'h0000000, 1, 32'h00000000, 3'b001};
        v[9]  = '{1'b0, 8'd3,   25'h0000004, 3, 32'h00000000, 3'b010};
        v[10] = '{1'b0, 8'd2,   25'h0400000, 2, 32'h00800000, 3'b000};
        v[11] = '{1'b0, 8'd1,   25'h0400000, 1, 32'h00000000, 3'b010};
        v[12] = '{1'b1, 8'd255, 25'h0000000, 1, 32'h00000000, 3'b001};
        for (int i = 0; i < 13; i++) begin
            run_op(v[i].s, v[i].e, v[i].m, lat, rs);
            checks++; if (lat != v[i].lat) begin errors++; $display("[TB] FAIL vec%0d_latency: got %0d expected %0d", i, lat, v[i].lat); end
            checks++; if (result !== v[i].res) begin errors++; $display("[TB] FAIL vec%0d_result: got %h expected %h", i, result, v[i].res); end
            checks++; if (flags !== v[i].flg) begin errors++; $display("[TB] FAIL vec%0d_flags: got %b expected %b", i, flags, v[i].flg); end
            ack();
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL vec%0d_release: got in_ready=%b out_valid=%b expected 1/0", i, in_ready, out_valid); end
        end
    endtask

    task automatic test_long_shift();
        int lat;
        bit rs;
        run_op(1'b0, 8'd30, 25'h0000001, lat, rs);
        checks++; if (lat != 24) begin errors++; $display("[TB] FAIL long_latency: got %0d expected 24", lat); end
        checks++; if (rs !== 1'b0) begin errors++; $display("[TB] FAIL long_in_ready: got in_ready seen=%b expected 0", rs); end
        checks++; if (result !== 32'h03800000) begin errors++; $display("[TB] FAIL long_result: got %h expected 03800000", result); end
        checks++; if (flags !== 3'b000) begin errors++; $display("[TB] FAIL long_flags: got %b expected 000", flags); end
        ack();
    endtask

    task automatic test_backpressure();
        int lat;
        bit rs;
        int late_valid = 0;
        run_op(1'b0, 8'd10, 25'h0800000, lat, rs);
        sign_in       = 1'b1;
        exponent_temp = 8'd40;
        sum_mant      = 25'h0800000;
        in_valid      = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold%0d: got out_valid=%b in_ready=%b expected 1/0", c, out_valid, in_ready); end
            checks++; if (result !== 32'h05000000 || flags !== 3'b000) begin errors++; $display("[TB] FAIL bp_stable%0d: got %h/%b expected 05000000/000", c, result, flags); end
        end
        in_valid = 1'b0;
        ack();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (out_valid) late_valid++;
        end
        checks++; if (late_valid != 0) begin errors++; $display("[TB] FAIL bp_no_accept: got %0d valid cycles expected 0", late_valid); end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit rs;
        run_op(1'b0, 8'd10, 25'h1000000, lat, rs);
        sign_in       = 1'b0;
        exponent_temp = 8'd20;
        sum_mant      = 25'h0800000;
        in_valid      = 1'b1;
        out_ready     = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept: got in_ready=%b expected 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || result !== 32'h0A000000) begin errors++; $display("[TB] FAIL b2b_result: got valid=%b result=%h expected 1/0A000000", out_valid, result); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_shift();
        int seen = 0;
        out_ready     = 1'b1;
        sign_in       = 1'b0;
        exponent_temp = 8'd30;
        sum_mant      = 25'h0000001;
        in_valid      = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got in_ready=%b out_valid=%b expected 0/0", in_ready, out_valid); end
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
        checks++; if (result !== 32'h0 || flags !== 3'b000) begin errors++; $display("[TB] FAIL rst_mid_clear: got %h/%b expected 00000000/000", result, flags); end
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("[TB] FAIL rst_mid_discard: got %0d valid cycles expected 0", seen); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_datapath();
        test_long_shift();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
